// File: rtl/vga_scan_if.sv
// Pixel-query and VGA pin bundle: the scan generator issues x/y, the renderers answer with colour.
// The master side drives coordinates and pins and receives the colour answer.
interface vga_scan_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        video_on;
   logic        frame_tick;
   logic [11:0] color;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        hsync;
   logic        vsync;

   modport master (
      output x, y, video_on, frame_tick, vga_r, vga_g, vga_b, hsync, vsync,
      input  color
   );

   modport slave (
      input  x, y, video_on, frame_tick, vga_r, vga_g, vga_b, hsync, vsync,
      output color
   );
endinterface

// File: rtl/vga_scan.sv
// 640x480@60 raster scan generator and pixel output stage; x/y to pins latency COLOR_LAT+1, no backpressure.
// Optional VGA_BORDER_EN forces a white one-pixel frame around the visible area for monitor alignment.
module vga_scan #(
   parameter int H_VIS     = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VIS     = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int COLOR_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   vga_scan_if.master pix
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == 10'(H_TOT - 1)) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == 10'(V_TOT - 1)) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   logic vid_raw;
   logic hs_raw;
   logic vs_raw;

   assign vid_raw = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
   assign hs_raw  = !((h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC)));
   assign vs_raw  = !((v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC)));

   // Raw controls ride a COLOR_LAT-deep line so they meet the colour answer.
   logic vid_d;
   logic hs_d;
   logic vs_d;
`ifdef VGA_BORDER_EN
   logic [9:0] x_d;
   logic [9:0] y_d;
`endif

   if (COLOR_LAT == 0) begin : g_nodl
      assign vid_d = vid_raw;
      assign hs_d  = hs_raw;
      assign vs_d  = vs_raw;
`ifdef VGA_BORDER_EN
      assign x_d = h_cnt;
      assign y_d = v_cnt;
`endif
   end else begin : g_dl
      logic [COLOR_LAT-1:0] vid_sr;
      logic [COLOR_LAT-1:0] hs_sr;
      logic [COLOR_LAT-1:0] vs_sr;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vid_sr <= '0;
            hs_sr  <= '1;
            vs_sr  <= '1;
         end else begin
            vid_sr <= COLOR_LAT'({vid_sr, vid_raw});
            hs_sr  <= COLOR_LAT'({hs_sr, hs_raw});
            vs_sr  <= COLOR_LAT'({vs_sr, vs_raw});
         end
      end

      assign vid_d = vid_sr[COLOR_LAT-1];
      assign hs_d  = hs_sr[COLOR_LAT-1];
      assign vs_d  = vs_sr[COLOR_LAT-1];

`ifdef VGA_BORDER_EN
      logic [9:0] x_sr [COLOR_LAT];
      logic [9:0] y_sr [COLOR_LAT];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int i = 0; i < COLOR_LAT; i++) begin
               x_sr[i] <= '0;
               y_sr[i] <= '0;
            end
         end else begin
            x_sr[0] <= h_cnt;
            y_sr[0] <= v_cnt;
            for (int i = 1; i < COLOR_LAT; i++) begin
               x_sr[i] <= x_sr[i-1];
               y_sr[i] <= y_sr[i-1];
            end
         end
      end

      assign x_d = x_sr[COLOR_LAT-1];
      assign y_d = y_sr[COLOR_LAT-1];
`endif
   end

   logic [11:0] rgb_nxt;

   always_comb begin
      rgb_nxt = '0;
      if (vid_d) begin
         rgb_nxt = pix.color;
`ifdef VGA_BORDER_EN
         if ((x_d == '0) || (x_d == 10'(H_VIS - 1)) || (y_d == '0) || (y_d == 10'(V_VIS - 1)))
            rgb_nxt = 12'hFFF;
`endif
      end
   end

   logic [11:0] rgb_q;
   logic        hs_q;
   logic        vs_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         rgb_q <= rgb_nxt;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   assign pix.x          = h_cnt;
   assign pix.y          = v_cnt;
   assign pix.video_on   = vid_raw;
   assign pix.frame_tick = (h_cnt == '0) && (v_cnt == 10'(V_VIS));
   assign pix.vga_r      = rgb_q[11:8];
   assign pix.vga_g      = rgb_q[7:4];
   assign pix.vga_b      = rgb_q[3:0];
   assign pix.hsync      = hs_q;
   assign pix.vsync      = vs_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: a full-timing and a shrunken-timing instance checked each cycle against a raster model.
module tb_vga_scan;

   localparam int CL = 1;
   localparam int D  = CL + 1;

   localparam int F_HV = 640, F_HF = 16, F_HS = 96, F_HB = 48;
   localparam int F_VV = 480, F_VF = 10, F_VS = 2,  F_VB = 33;
   localparam int S_HV = 20,  S_HF = 4,  S_HS = 6,  S_HB = 2;
   localparam int S_VV = 10,  S_VF = 2,  S_VS = 3,  S_VB = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_scan_if if0();
   vga_scan_if if1();

   vga_scan #(.COLOR_LAT(CL)) u_full (
      .clk(clk), .rst_n(rst_n), .pix(if0)
   );

   vga_scan #(
      .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .COLOR_LAT(CL)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .pix(if1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int mode  = 1;

   // per-instance bookkeeping
   logic [11:0] last_drv [2];
   logic        prev_hs [2];
   logic        prev_vs [2];
   int hs_fall [2], vs_fall [2], first_hs [2], first_vs [2];
   int hs_w [2], vs_w [2], vs_p [2], first_ft [2], f88_cnt [2], f88_at [2];

   task automatic cmp(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [11:0] src(input int h, input int v);
      case (mode)
         0:       return 12'h000;
         1:       return (h == 100 && v == 50) ? 12'hF88 : 12'h000;
         2:       return 12'hFFF;
         default: return 12'(h * 37 + v * 11 + 5);
      endcase
   endfunction

   function automatic logic [11:0] drv_val(input int n, input int ht, input int vt);
      int m;
      m = n - CL;
      if (m < 0) return 12'hABC;
      return src(m % ht, (m / ht) % vt);
   endfunction

   task automatic chk(input int id, input int n,
                      input int hv, input int hf, input int hsw, input int hb,
                      input int vv, input int vf, input int vsw, input int vb,
                      input logic [9:0] ax, input logic [9:0] ay,
                      input logic avo, input logic aft,
                      input logic [11:0] argb, input logic ahs, input logic avs);
      int ht, vt, h, v, m, ph, pv;
      logic vis;
      logic [11:0] er;
      logic [35:0] e;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      if (n == 0) begin
         prev_hs[id] = 1'b1; prev_vs[id] = 1'b1;
         hs_fall[id] = -1; vs_fall[id] = -1; first_hs[id] = -1; first_vs[id] = -1;
         hs_w[id] = -1; vs_w[id] = -1; vs_p[id] = -1; first_ft[id] = -1;
         f88_cnt[id] = 0; f88_at[id] = -1;
      end
      e[35:26] = 10'(h);
      e[25:16] = 10'(v);
      e[15]    = (h < hv) && (v < vv);
      e[14]    = (h == 0) && (v == vv);
      if (n < D) begin
         e[13:0] = {12'h000, 1'b1, 1'b1};
      end else begin
         m   = n - D;
         ph  = m % ht;
         pv  = (m / ht) % vt;
         vis = (ph < hv) && (pv < vv);
         er  = vis ? last_drv[id] : 12'h000;
`ifdef VGA_BORDER_EN
         if (vis && (ph == 0 || ph == hv - 1 || pv == 0 || pv == vv - 1)) er = 12'hFFF;
`endif
         e[13:2] = er;
         e[1]    = !((ph >= hv + hf) && (ph < hv + hf + hsw));
         e[0]    = !((pv >= vv + vf) && (pv < vv + vf + vsw));
      end
      cmp($sformatf("pix%0d@%0d {x,y,vo,ft,rgb,hs,vs}", id, n),
          longint'({ax, ay, avo, aft, argb, ahs, avs}), longint'(e));

      if (argb == 12'hF88) begin
         f88_cnt[id]++;
         f88_at[id] = n;
      end
      if (aft && first_ft[id] < 0) first_ft[id] = n;
      if (!ahs && prev_hs[id]) begin
         if (hs_fall[id] < 0) first_hs[id] = n;
         else cmp($sformatf("hs_period%0d", id), n - hs_fall[id], ht);
         hs_fall[id] = n;
      end
      if (ahs && !prev_hs[id] && hs_fall[id] >= 0) begin
         hs_w[id] = n - hs_fall[id];
         cmp($sformatf("hs_width%0d", id), hs_w[id], hsw);
      end
      if (!avs && prev_vs[id]) begin
         if (vs_fall[id] < 0) first_vs[id] = n;
         else vs_p[id] = n - vs_fall[id];
         vs_fall[id] = n;
      end
      if (avs && !prev_vs[id] && vs_fall[id] >= 0) vs_w[id] = n - vs_fall[id];
      prev_hs[id] = ahs;
      prev_vs[id] = avs;
   endtask

   // single compare/drive process, mid-cycle
   logic prev_rst = 1'b1;
   logic started  = 1'b0;
   int   cyc      = 0;

   always @(negedge clk) begin
      if (!prev_rst) begin
         started = 1'b1;
         cyc = 0;
      end else if (started) begin
         cyc++;
      end
      prev_rst = rst_n;
      if (started) begin
         chk(0, cyc, F_HV, F_HF, F_HS, F_HB, F_VV, F_VF, F_VS, F_VB,
             if0.x, if0.y, if0.video_on, if0.frame_tick,
             {if0.vga_r, if0.vga_g, if0.vga_b}, if0.hsync, if0.vsync);
         chk(1, cyc, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
             if1.x, if1.y, if1.video_on, if1.frame_tick,
             {if1.vga_r, if1.vga_g, if1.vga_b}, if1.hsync, if1.vsync);
         last_drv[0] = drv_val(cyc, F_HV + F_HF + F_HS + F_HB, F_VV + F_VF + F_VS + F_VB);
         last_drv[1] = drv_val(cyc, S_HV + S_HF + S_HS + S_HB, S_VV + S_VF + S_VS + S_VB);
         if0.color = last_drv[0];
         if1.color = last_drv[1];
      end else begin
         if0.color = 12'h000;
         if1.color = 12'h000;
      end
   end

   initial begin
      bit found;
      mode  = 1;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      cmp("rst_rgb", {if0.vga_r, if0.vga_g, if0.vga_b}, 0);
      cmp("rst_hsync", if0.hsync, 1);
      cmp("rst_vsync", if0.vsync, 1);
      cmp("rst_ft", if0.frame_tick, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk); #1;
      cmp("rel_x", if0.x, 0);
      cmp("rel_y", if0.y, 0);

      // single F88 pixel at (100,50) must land on cycle 50*800+100+2
      repeat (41000) @(posedge clk);
      #2;
      cmp("first_hs_fall", first_hs[0], 658);
      cmp("hs_low_width", hs_w[0], 96);
      cmp("f88_count", f88_cnt[0], 1);
      cmp("f88_cycle", f88_at[0], 40102);
      cmp("f88_small", f88_cnt[1], 0);
      cmp("small_first_vs", first_vs[1], 386);
      cmp("small_vs_width", vs_w[1], 96);
      cmp("small_vs_period", vs_p[1], 544);
      cmp("small_first_ft", first_ft[1], 320);
      cmp("full_no_ft", first_ft[0], -1);

      mode = 2;
      repeat (2000) @(posedge clk);
      mode = 3;
      repeat (2000) @(posedge clk);

      // abort mid-line at x=300
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(posedge clk); #2;
         if (if0.x == 10'd300) found = 1'b1;
      end
      cmp("x300_reached", found, 1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk); #1;
      cmp("abort_x", if0.x, 0);
      cmp("abort_y", if0.y, 0);
      cmp("abort_rgb", {if0.vga_r, if0.vga_g, if0.vga_b}, 0);
      cmp("abort_hsync", if0.hsync, 1);
      cmp("abort_small_x", if1.x, 0);
      mode = 0;
      repeat (600) @(posedge clk);
      #2;
      cmp("abort_first_ft", first_ft[1], 320);
      cmp("abort_full_no_ft", first_ft[0], -1);
      repeat (1200) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster scan generator and pixel output stage for the VGA display path: it produces the pixel coordinates that the fruit, blade and score renderers evaluate, samples their 12-bit colour answer, and drives the VGA connector with RGB and sync signals aligned to that answer. It is the consumer end of the x/y to colour pixel-query interface. It runs on the 25 MHz pixel clock, one pixel per cycle, with 640x480 at 60 Hz timing.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLOR_LAT, 1, cycles from x/y to the matching colour (range 0..4)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst_n  in  1  reset; synchronous, active-low
- x  out  10  current horizontal coordinate (raw counter)
- y  out  10  current vertical coordinate (raw counter)
- video_on  out  1  high when x < H_VIS and y < V_VIS (undelayed)
- frame_tick  out  1  one-cycle pulse at x=0, y=V_VIS (start of vertical blank)
- color  in  12  {R[3:0],G[3:0],B[3:0]} for the coordinate issued COLOR_LAT cycles earlier
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low

## Operation
- h_cnt counts 0..H_TOT-1, where H_TOT = 800, then wraps to 0. v_cnt advances only on an h_cnt wrap and counts 0..V_TOT-1, where V_TOT = 525, then wraps to 0.
- x = h_cnt and y = v_cnt, both registered, and they keep counting through blanking.
- Raw hsync is low for H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751). Raw vsync is low for 490 <= v_cnt < 492.
- Raw video_on, hsync and vsync enter a COLOR_LAT-deep shift register so they align with the arriving `color`.
- Output stage, registered each cycle:
  - {vga_r,vga_g,vga_b} = delayed video_on ? color : 0.
  - hsync and vsync take their delayed values.
- frame_tick is decoded from the registered counters with no delay.
- Reset, applied when rst_n is low at a clk edge:
  - h_cnt and v_cnt return to 0.
  - The delay line clears to video_on=0, hsync=1, vsync=1.
  - The outputs become rgb=0, hsync=1, vsync=1, frame_tick=0.
  - Reset asserted mid-frame aborts the frame. The first cycle after release presents x=0, y=0.
- `color` is ignored whenever its delayed video_on is 0. Out-of-range colour values cannot occur because all 12 bits pass through unchanged.

## Timing
- Total output latency from x/y to RGB and sync is D = COLOR_LAT+1 cycles. Coordinate (h,v) issued at cycle t appears on the pins at cycle t+D.
- Sync widths are exactly H_SYNC clocks and V_SYNC lines. The line period is 800 clocks and the frame period is 420000 clocks.
- After reset release:
  - The x/y sequence starts at (0,0).
  - The pins show blank with inactive sync for D cycles.
  - Pixel (0,0) appears at cycle D.
- The line wrap (799 to 0) and the v increment happen on the same edge. At (799,524) both counters wrap to (0,0) on that edge.
- frame_tick is high for exactly one cycle per frame, on the cycle where x=0 and y=480.

## Configuration
- VGA_BORDER_EN:
  - When defined, the output stage forces colour 12'hFFF wherever the delayed coordinate satisfies x=0, x=H_VIS-1, y=0 or y=V_VIS-1, overriding `color`. This is used for monitor alignment. It requires x and y to be delayed alongside video_on.
  - When undefined, no border logic or coordinate delay is present, and the output is `color` gated by video_on only.

## Test plan
- Reset hold, then release. rgb=0, hsync=1 and vsync=1 during reset. x,y = 0,0 on the first cycle after release. First hsync low when x=656+D cycles earlier, lasting 96 cycles.
- Run 2 frames. Check 800 clocks between hsync falling edges, vsync low for exactly 1600 clocks, and 420000 clocks between vsync falling edges.
- Run with COLOR_LAT=1 and a model colour source that returns 12'hF88 only for (100,50), 1 cycle late. Exactly one output pixel equals F88, at cycle t(100,50)+2. All other pixels are 0.
- Drive color=12'hFFF constantly. RGB is 0 for h>=640 or v>=480 (output-aligned), and all ones inside the visible area.
- Assert rst_n=0 at x=300, y=200 for 3 cycles. Next cycle x=0, y=0, pins blank, frame_tick not pulsed until y reaches 480.
- With VGA_BORDER_EN defined and color=0: pixels (0,k), (639,k), (k,0) and (k,479) are FFF, interior is 0. Without it, all pixels are 0.
